dffram_nibble_host: RTL and testbench

//  Byte-wide host sequencer for the 2R1W nibble-pin DFF RAM: turns one byte request into nibble pin cycles.
//  A write is two nibble writes on port A. A read fetches both nibbles on ports A and B in parallel.

---
 rtl/dffram_nibble_host_pkg.sv | 18 +
 rtl/dffram_nibble_host_if.sv | 40 ++++
 rtl/dffram_nibble_host.sv | 130 +++++++++++++
 tb/tb_dffram_nibble_host.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dffram_nibble_host_pkg.sv
// Shared types and constants for the byte-wide host sequencer of the nibble-pin DFF RAM.
package dffram_nibble_host_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_LO   = 3'd2,
        RD_HI   = 3'd3,
        WR_LO   = 3'd4,
        WR_HI   = 3'd5,
        RESP    = 3'd6
    } state_t;

    // The RAM's half-select is inverted between writes and reads.
    localparam logic LOHI_WR_LO = 1'b1;
    localparam logic LOHI_RD_LO = 1'b0;

endpackage

// File: rtl/dffram_nibble_host_if.sv
// Host request/response channel plus RAM pin bundle for the nibble host sequencer.
interface dffram_nibble_host_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [AWIDTH-1:0]     req_addr_a;
    logic [AWIDTH-1:0]     req_addr_b;
    logic [2*DWIDTH-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [2*DWIDTH-1:0]   rsp_rdata_a;
    logic [2*DWIDTH-1:0]   rsp_rdata_b;
    logic [AWIDTH-1:0]     mem_addr_a;
    logic [AWIDTH-1:0]     mem_addr_b;
    logic [DWIDTH-1:0]     mem_wdata;
    logic                  mem_lohi_a;
    logic                  mem_lohi_b;
    logic                  mem_w_en;
    logic [DWIDTH-1:0]     mem_rdata_a;
    logic [DWIDTH-1:0]     mem_rdata_b;

    modport master (
        output req_valid, req_write, req_addr_a, req_addr_b, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata_a, rsp_rdata_b
    );

    modport slave (
        input  req_valid, req_write, req_addr_a, req_addr_b, req_wdata,
        output req_ready, rsp_valid, rsp_rdata_a, rsp_rdata_b,
        output mem_addr_a, mem_addr_b, mem_wdata, mem_lohi_a, mem_lohi_b, mem_w_en,
        input  mem_rdata_a, mem_rdata_b
    );

    modport ram (
        input  mem_addr_a, mem_addr_b, mem_wdata, mem_lohi_a, mem_lohi_b, mem_w_en,
        output mem_rdata_a, mem_rdata_b
    );
endinterface

// File: rtl/dffram_nibble_host.sv
// Turns one byte request into nibble pin cycles on the 2R1W DFF RAM; all RAM pins are registered.
module dffram_nibble_host
    import dffram_nibble_host_pkg::*;
#(
    parameter int AWIDTH       = 4,
    parameter int DWIDTH       = 4,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dffram_nibble_host_if.slave   bus
);

    localparam int BYTEW = 2 * DWIDTH;

    state_t              state_reg, state_next;
    logic                accept;
    logic [BYTEW-1:0]    data_sel;
    logic [BYTEW-1:0]    wdata_reg;
    logic [AWIDTH-1:0]   addr_a_reg, addr_b_reg;
    logic [DWIDTH-1:0]   wdata_pin_reg, wdata_pin_next;
    logic                lohi_a_reg, lohi_a_next;
    logic                lohi_b_reg, lohi_b_next;
    logic                w_en_reg, w_en_next;
    logic [DWIDTH-1:0]   lo_a_reg, lo_b_reg;
    logic [BYTEW-1:0]    rdata_a_reg, rdata_b_reg;

    assign accept = bus.req_valid && (state_reg == IDLE);

    always_comb begin
        state_next     = state_reg;
        lohi_a_next    = 1'b0;
        lohi_b_next    = 1'b0;
        w_en_next      = 1'b0;
        wdata_pin_next = '0;
        // On the accept edge the byte is not yet in wdata_reg, so take it from the request.
        data_sel       = accept ? bus.req_wdata : wdata_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.req_write)          state_next = WR_LO;
                    else if (READ_LATENCY != 0) state_next = RD_WAIT;
                    else                        state_next = RD_LO;
                end
            end
            RD_WAIT: state_next = RD_LO;
            RD_LO:   state_next = RD_HI;
            RD_HI:   state_next = RESP;
            WR_LO:   state_next = WR_HI;
            WR_HI:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Pin values are decoded from the next state so they appear in the same cycle as the state.
        unique case (state_next)
            WR_LO: begin
                lohi_a_next    = LOHI_WR_LO;
                w_en_next      = 1'b1;
                wdata_pin_next = data_sel[DWIDTH-1:0];
            end
            WR_HI: begin
                lohi_a_next    = ~LOHI_WR_LO;
                w_en_next      = 1'b1;
                wdata_pin_next = data_sel[BYTEW-1:DWIDTH];
            end
            RD_WAIT, RD_LO: begin
                lohi_a_next = LOHI_RD_LO;
                lohi_b_next = LOHI_RD_LO;
            end
            RD_HI: begin
                lohi_a_next = ~LOHI_RD_LO;
                lohi_b_next = ~LOHI_RD_LO;
            end
            default: begin
                lohi_a_next = 1'b0;
                lohi_b_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wdata_reg     <= '0;
            addr_a_reg    <= '0;
            addr_b_reg    <= '0;
            wdata_pin_reg <= '0;
            lohi_a_reg    <= 1'b0;
            lohi_b_reg    <= 1'b0;
            w_en_reg      <= 1'b0;
            lo_a_reg      <= '0;
            lo_b_reg      <= '0;
            rdata_a_reg   <= '0;
            rdata_b_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            wdata_pin_reg <= wdata_pin_next;
            lohi_a_reg    <= lohi_a_next;
            lohi_b_reg    <= lohi_b_next;
            w_en_reg      <= w_en_next;
            if (accept) begin
                wdata_reg  <= bus.req_wdata;
                addr_a_reg <= bus.req_addr_a;
                if (!bus.req_write) addr_b_reg <= bus.req_addr_b;
            end
            if (state_reg == RD_LO) begin
                lo_a_reg <= bus.mem_rdata_a;
                lo_b_reg <= bus.mem_rdata_b;
            end
            if (state_reg == RD_HI) begin
                rdata_a_reg <= {bus.mem_rdata_a, lo_a_reg};
                rdata_b_reg <= {bus.mem_rdata_b, lo_b_reg};
            end
        end
    end

    assign bus.req_ready   = (state_reg == IDLE);
    assign bus.rsp_valid   = (state_reg == RESP);
    assign bus.rsp_rdata_a = rdata_a_reg;
    assign bus.rsp_rdata_b = rdata_b_reg;
    assign bus.mem_addr_a  = addr_a_reg;
    assign bus.mem_addr_b  = addr_b_reg;
    assign bus.mem_wdata   = wdata_pin_reg;
    assign bus.mem_lohi_a  = lohi_a_reg;
    assign bus.mem_lohi_b  = lohi_b_reg;
    assign bus.mem_w_en    = w_en_reg;

endmodule

// File: tb/tb_dffram_nibble_host.sv
// Directed bench: two host instances (combinational and buffered RAM read) sharing one behavioural RAM.
module tb_dffram_nibble_host;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dffram_nibble_host_if #(.AWIDTH(4), .DWIDTH(4)) if0 ();
    dffram_nibble_host_if #(.AWIDTH(4), .DWIDTH(4)) if1 ();

    dffram_nibble_host #(.AWIDTH(4), .DWIDTH(4), .READ_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );
    dffram_nibble_host #(.AWIDTH(4), .DWIDTH(4), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    // Behavioural RAM with the half-select quirk: write lohi=1 -> [3:0], read lohi=0 -> [3:0].
    logic [7:0] mem [16];
    logic [7:0] buf_a, buf_b;

    always @(posedge clk) begin
        if (if0.mem_w_en) begin
            if (if0.mem_lohi_a) mem[if0.mem_addr_a][3:0] <= if0.mem_wdata;
            else                mem[if0.mem_addr_a][7:4] <= if0.mem_wdata;
        end
        if (if1.mem_w_en) begin
            if (if1.mem_lohi_a) mem[if1.mem_addr_a][3:0] <= if1.mem_wdata;
            else                mem[if1.mem_addr_a][7:4] <= if1.mem_wdata;
        end
        buf_a <= mem[if1.mem_addr_a];
        buf_b <= mem[if1.mem_addr_b];
    end

    assign if0.mem_rdata_a = if0.mem_lohi_a ? mem[if0.mem_addr_a][7:4] : mem[if0.mem_addr_a][3:0];
    assign if0.mem_rdata_b = if0.mem_lohi_b ? mem[if0.mem_addr_b][7:4] : mem[if0.mem_addr_b][3:0];
    assign if1.mem_rdata_a = if1.mem_lohi_a ? buf_a[7:4] : buf_a[3:0];
    assign if1.mem_rdata_b = if1.mem_lohi_b ? buf_b[7:4] : buf_b[3:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit lat1, input logic v, input logic wr,
                         input logic [3:0] a, input logic [3:0] b, input logic [7:0] d);
        if (lat1) begin
            if1.req_valid = v; if1.req_write = wr; if1.req_addr_a = a;
            if1.req_addr_b = b; if1.req_wdata = d;
        end else begin
            if0.req_valid = v; if0.req_write = wr; if0.req_addr_a = a;
            if0.req_addr_b = b; if0.req_wdata = d;
        end
    endtask

    // Starts and ends on a negedge; cyc = negedges after accept until rsp_valid (0 = timeout).
    task automatic run_req(input bit lat1, input logic wr, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] d, output int cyc, output logic [7:0] ra,
                           output logic [7:0] rb, output bit wen_seen);
        drive(lat1, 1'b1, wr, a, b, d);
        @(posedge clk);
        @(negedge clk);
        drive(lat1, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
        cyc = 0; ra = 8'd0; rb = 8'd0; wen_seen = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (lat1 ? if1.mem_w_en : if0.mem_w_en) wen_seen = 1'b1;
            if (lat1 ? if1.rsp_valid : if0.rsp_valid) begin
                cyc = i;
                ra  = lat1 ? if1.rsp_rdata_a : if0.rsp_rdata_a;
                rb  = lat1 ? if1.rsp_rdata_b : if0.rsp_rdata_b;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        $display("txn lat=%0d wr=%0d a=%0d b=%0d d=0x%02h -> cyc=%0d ra=0x%02h rb=0x%02h",
                 lat1, wr, a, b, d, cyc, ra, rb);
    endtask

    int         cyc;
    logic [7:0] ra, rb;
    bit         wen_seen;
    int         rsp_seen;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_ready0", if0.req_ready, 1);
        check("rst_ready1", if1.req_ready, 1);
        check("rst_wen0",   if0.mem_w_en, 0);
        check("rst_wen1",   if1.mem_w_en, 0);
        check("rst_rsp0",   if0.rsp_valid, 0);
        check("rst_pins0",  {if0.mem_addr_a, if0.mem_addr_b, if0.mem_wdata, if0.mem_lohi_a, if0.mem_lohi_b}, 0);
        check("rst_rdata0", {if0.rsp_rdata_a, if0.rsp_rdata_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write 0xA5 @3, pin-level sequence
        drive(1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 8'hA5);
        check("t1_ready", if0.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
        check("t1_wrlo_pins", {if0.mem_lohi_a, if0.mem_wdata, if0.mem_w_en, if0.mem_addr_a}, {1'b1, 4'h5, 1'b1, 4'd3});
        check("t1_wrlo_ready", if0.req_ready, 0);
        @(negedge clk);
        check("t1_wrhi_pins", {if0.mem_lohi_a, if0.mem_wdata, if0.mem_w_en}, {1'b0, 4'hA, 1'b1});
        check("t1_lo_nibble", mem[3][3:0], 4'h5);
        @(negedge clk);
        check("t1_resp", {if0.rsp_valid, if0.mem_w_en}, 2'b10);
        @(negedge clk);
        check("t1_idle", {if0.rsp_valid, if0.req_ready}, 2'b01);
        check("t1_mem", mem[3], 8'hA5);
        $display("txn lat=0 wr=1 a=3 d=0xa5 pin sequence done");

        // 2: read A=3 B=3, combinational RAM
        run_req(1'b0, 1'b0, 4'd3, 4'd3, 8'd0, cyc, ra, rb, wen_seen);
        check("t2_cyc", cyc, 3);
        check("t2_rdata", {ra, rb}, 16'hA5A5);
        check("t2_wen", wen_seen, 0);

        // 3: two writes then a dual-port read
        run_req(1'b0, 1'b1, 4'd7, 4'd0, 8'h3C, cyc, ra, rb, wen_seen);
        check("t3_w7_cyc", cyc, 3);
        check("t3_w7_rdhold", ra, 8'hA5);
        run_req(1'b0, 1'b1, 4'd9, 4'd0, 8'hF0, cyc, ra, rb, wen_seen);
        check("t3_w9_cyc", cyc, 3);
        run_req(1'b0, 1'b0, 4'd7, 4'd9, 8'd0, cyc, ra, rb, wen_seen);
        check("t3_cyc", cyc, 3);
        check("t3_rdata", {ra, rb}, 16'h3CF0);

        // 4: buffered RAM read, one extra cycle
        run_req(1'b1, 1'b0, 4'd3, 4'd9, 8'd0, cyc, ra, rb, wen_seen);
        check("t4_cyc", cyc, 4);
        check("t4_rdata", {ra, rb}, 16'hA5F0);
        check("t4_wen", wen_seen, 0);
        run_req(1'b1, 1'b1, 4'd4, 4'd0, 8'h5A, cyc, ra, rb, wen_seen);
        check("t4_w4_cyc", cyc, 3);
        check("t4_w4_rdhold", {ra, rb}, 16'hA5F0);
        run_req(1'b0, 1'b0, 4'd4, 4'd3, 8'd0, cyc, ra, rb, wen_seen);
        check("t4_cross_rdata", {ra, rb}, 16'h5AA5);

        // 5: req_valid held high across a write; next request only taken in IDLE
        drive(1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 8'h11);
        @(posedge clk);
        @(negedge clk);
        check("t5_ready_wrlo", if0.req_ready, 0);
        drive(1'b0, 1'b1, 1'b0, 4'd5, 4'd4, 8'h00);
        @(negedge clk);
        check("t5_ready_wrhi", if0.req_ready, 0);
        @(negedge clk);
        check("t5_resp", {if0.req_ready, if0.rsp_valid, if0.mem_w_en}, 3'b010);
        check("t5_rdhold", if0.rsp_rdata_a, 8'h5A);
        @(negedge clk);
        check("t5_idle_ready", if0.req_ready, 1);
        check("t5_mem", mem[5], 8'h11);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
        check("t5_rdlo", {if0.req_ready, if0.mem_lohi_a, if0.mem_w_en}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        check("t5_rd_resp", if0.rsp_valid, 1);
        check("t5_rd_rdata", {if0.rsp_rdata_a, if0.rsp_rdata_b}, 16'h115A);
        @(negedge clk);
        $display("txn lat=0 held-valid write 0x11@5 then read a=5 b=4 done");

        // 6: reset asserted during WR_HI leaves the byte half-written
        drive(1'b0, 1'b1, 1'b1, 4'd7, 4'd0, 8'h47);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
        @(negedge clk);
        check("t6_wrhi_wen", if0.mem_w_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_wen", if0.mem_w_en, 0);
        check("t6_rst_ready", if0.req_ready, 1);
        check("t6_rst_rsp", if0.rsp_valid, 0);
        rsp_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (if0.rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        check("t6_no_rsp", rsp_seen, 0);
        check("t6_halfwritten", mem[7], 8'h37);
        run_req(1'b0, 1'b0, 4'd7, 4'd7, 8'd0, cyc, ra, rb, wen_seen);
        check("t6_read_cyc", cyc, 3);
        check("t6_read_rdata", {ra, rb}, 16'h3737);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
